// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the MEM stage and the data-memory responder.
// The requester drives the request fields; the responder returns busywait, load data and the error flag.
interface data_mem_responder_if;
  logic        req_load_i;
  logic        req_store_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  funct3_i;
  logic        busywait_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_load_i, req_store_i, addr_i, wdata_i, funct3_i,
    input  busywait_o, rdata_o, err_o
  );

  modport slave (
    input  req_load_i, req_store_i, addr_i, wdata_i, funct3_i,
    output busywait_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word-addressed data SRAM model with byte/half lane steering and load extension.
// Optional macro MISALIGN_TRAP_EN: trap misaligned/illegal accesses (no write, rdata 0, err_o pulse).
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  data_mem_responder_if.slave  bus
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_r, state_nx_s;
  logic [3:0]            cnt_r, cnt_nx_s;
  logic [ADDR_WIDTH+1:0] addr_r;
  logic [31:0]           wdata_r;
  logic [2:0]            funct3_r;
  logic                  store_r;
  logic [31:0]           rdata_r;
  logic                  err_r;
  logic [31:0]           mem_r [0:DEPTH-1];

  logic                  req_s;
  logic                  commit_s;
  logic [ADDR_WIDTH+1:0] acc_addr_s;
  logic [31:0]           acc_wdata_s;
  logic [2:0]            acc_funct3_s;
  logic                  acc_store_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic [1:0]            lane_s;
  logic                  illegal_s;
  logic                  misalign_s;
  logic                  trap_s;
  logic                  wr_en_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_lanes_s;
  logic [31:0]           rd_word_s;
  logic                  unused_s;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return lane[1] ? 4'b1100 : 4'b0011;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return {4{wd[7:0]}};
      3'b001:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  assign req_s = bus.req_load_i | bus.req_store_i;

  // In IDLE the live request is the access source, so LATENCY==1 can commit without a captured copy
  always_comb begin
    if (state_r == IDLE) begin
      acc_addr_s   = bus.addr_i[ADDR_WIDTH+1:0];
      acc_wdata_s  = bus.wdata_i;
      acc_funct3_s = bus.funct3_i;
      acc_store_s  = bus.req_store_i;
    end else begin
      acc_addr_s   = addr_r;
      acc_wdata_s  = wdata_r;
      acc_funct3_s = funct3_r;
      acc_store_s  = store_r;
    end
  end

  assign idx_s  = acc_addr_s[ADDR_WIDTH+1:2];
  assign lane_s = acc_addr_s[1:0];

  // Legality and natural-alignment decode of the access in flight
  always_comb begin
    case (acc_funct3_s)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = acc_store_s;
      default:                illegal_s = 1'b1;
    endcase
    case (acc_funct3_s[1:0])
      2'b01:   misalign_s = lane_s[0];
      2'b10:   misalign_s = (lane_s != 2'b00);
      default: misalign_s = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap_s   = illegal_s | misalign_s;
  assign unused_s = ^bus.addr_i[31:ADDR_WIDTH+2];
`else
  assign trap_s   = 1'b0;
  assign unused_s = ^{bus.addr_i[31:ADDR_WIDTH+2], illegal_s, misalign_s};
`endif

  // Next-state and countdown logic
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (LATENCY == 32'sd1) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = ACCESS;
            cnt_nx_s   = CNT_INIT;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = DONE;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  assign commit_s      = (state_nx_s == DONE) && (state_r != DONE);
  assign wr_en_s       = commit_s & acc_store_s & ~trap_s;
  assign be_s          = store_be(acc_funct3_s, lane_s);
  assign wdata_lanes_s = store_lanes(acc_funct3_s, acc_wdata_s);
  assign rd_word_s     = mem_r[idx_s];

  // FSM state, request capture and registered load result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= '0;
      wdata_r  <= 32'd0;
      funct3_r <= 3'd0;
      store_r  <= 1'b0;
      rdata_r  <= 32'd0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if (state_r == IDLE && req_s) begin
        addr_r   <= bus.addr_i[ADDR_WIDTH+1:0];
        wdata_r  <= bus.wdata_i;
        funct3_r <= bus.funct3_i;
        store_r  <= bus.req_store_i;
      end
      err_r <= commit_s & trap_s;
      if (commit_s) begin
        if (trap_s) begin
          rdata_r <= 32'd0;
        end else if (!acc_store_s) begin
          rdata_r <= load_extract(rd_word_s, acc_funct3_s, lane_s);
        end
      end
    end
  end

  // Byte-enabled write on the edge entering DONE; reset suppresses the commit
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_lanes_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.busywait_o = rst_ni & (((state_r == IDLE) & req_s) | (state_r == ACCESS));
  assign bus.rdata_o    = rdata_r;
  assign bus.err_o      = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-level memory model predicts load results,
// err_o and busywait length; a LATENCY=1 instance checks the short busy pattern.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_responder_if bus3();
  data_mem_responder_if bus1();

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus3.slave)
  );
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave)
  );

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [0:1023];
  logic [31:0] last_rdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [2:0] f3);
    int sz = acc_size(f3);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
  endfunction

  task automatic idle3();
    bus3.req_load_i  = 1'b0;
    bus3.req_store_i = 1'b0;
    bus3.addr_i      = 32'd0;
    bus3.wdata_i     = 32'd0;
    bus3.funct3_i    = 3'd0;
  endtask

  // Drive a request on the LATENCY=3 bus and push its predicted completion
  task automatic drive(input bit ld, input bit st, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    exp_t        e;
    bit          legal;
    bit          bad;
    int          sz;
    logic [31:0] base;
    logic [31:0] r;
    bus3.req_load_i  = ld;
    bus3.req_store_i = st;
    bus3.addr_i      = a;
    bus3.wdata_i     = wd;
    bus3.funct3_i    = f3;
    sz   = acc_size(f3);
    base = a & ~(32'(sz) - 32'd1);
    if (st) begin
      legal = f3 inside {3'b000, 3'b001, 3'b010};
      bad   = TRAP && (!legal || misaligned(a, f3));
      if (legal && !bad) begin
        for (int i = 0; i < sz; i++) begin
          logic [31:0] b;
          b = base + 32'(i);
          mdl[b[11:2]][{b[1:0], 3'b000} +: 8] = wd[8*i +: 8];
        end
      end
      if (bad) last_rdata = 32'd0;
    end else begin
      legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      bad   = TRAP && (!legal || misaligned(a, f3));
      r = 32'd0;
      if (legal && !bad) begin
        for (int i = 0; i < sz; i++) begin
          logic [31:0] b;
          b = base + 32'(i);
          r[8*i +: 8] = mdl[b[11:2]][{b[1:0], 3'b000} +: 8];
        end
        if (!f3[2] && sz < 4 && r[8*sz-1]) r = r | ~((32'd1 << (8*sz)) - 32'd1);
      end
      last_rdata = r;
    end
    e.rdata = last_rdata;
    e.err   = bad;
    sb_q.push_back(e);
  endtask

  // Count busy cycles up to the DONE cycle, then compare against the scoreboard head
  task automatic wait_done(input string tag, input int exp_busy, input bit hold);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (bus3.busywait_o === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
    e = sb_q.pop_front();
    chk({tag, "_rdata"}, bus3.rdata_o, e.rdata);
    chk({tag, "_err"}, 32'(bus3.err_o), 32'(e.err));
    @(posedge clk);
    #1;
    if (!hold) idle3();
  endtask

  task automatic acc(input string tag, input bit ld, input bit st, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] f3);
    drive(ld, st, a, wd, f3);
    wait_done(tag, 3, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    last_rdata = 32'd0;
    idle3();
    bus1.req_load_i = 1'b0; bus1.req_store_i = 1'b0;
    bus1.addr_i = 32'd0; bus1.wdata_i = 32'd0; bus1.funct3_i = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    bus3.req_load_i = 1'b1;
    #1;
    chk("rst_busy", 32'(bus3.busywait_o), 32'd0);
    chk("rst_rdata", bus3.rdata_o, 32'd0);
    chk("rst_err", 32'(bus3.err_o), 32'd0);
    idle3();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    acc("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    acc("lw10", 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);

    acc("sw10b", 1'b0, 1'b1, 32'h10, 32'h11223344, 3'b010);
    acc("sb13", 1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000);
    acc("lw10b", 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    acc("lb13", 1'b1, 1'b0, 32'h13, 32'd0, 3'b000);
    acc("lbu13", 1'b1, 1'b0, 32'h13, 32'd0, 3'b100);

    acc("sw20", 1'b0, 1'b1, 32'h20, 32'h00000000, 3'b010);
    acc("sh22", 1'b0, 1'b1, 32'h22, 32'h0000A5A5, 3'b001);
    acc("lw20", 1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
    acc("lh22", 1'b1, 1'b0, 32'h22, 32'd0, 3'b001);
    acc("lhu22", 1'b1, 1'b0, 32'h22, 32'd0, 3'b101);
    acc("lb11", 1'b1, 1'b0, 32'h11, 32'd0, 3'b000);

    drive(1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    wait_done("b2b_1", 3, 1'b1);
    drive(1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
    wait_done("b2b_2", 3, 1'b0);

    acc("lw11_mis", 1'b1, 1'b0, 32'h11, 32'd0, 3'b010);
    acc("sw22_mis", 1'b0, 1'b1, 32'h22, 32'h55667788, 3'b010);
    acc("lw20_after", 1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
    acc("sh23_mis", 1'b0, 1'b1, 32'h23, 32'h0000BEEF, 3'b001);
    acc("lw20_after2", 1'b1, 1'b0, 32'h20, 32'd0, 3'b010);

    acc("sw1000", 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 3'b010);
    acc("lw0_alias", 1'b1, 1'b0, 32'h0, 32'd0, 3'b010);

    acc("both", 1'b1, 1'b1, 32'h30, 32'h01020304, 3'b010);
    acc("lw30", 1'b1, 1'b0, 32'h30, 32'd0, 3'b010);
    acc("ld_ill", 1'b1, 1'b0, 32'h10, 32'd0, 3'b011);
    acc("st_ill", 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 3'b110);
    acc("lw30b", 1'b1, 1'b0, 32'h30, 32'd0, 3'b010);

    // Reset mid-store: nothing may commit
    acc("sw40", 1'b0, 1'b1, 32'h40, 32'h12345678, 3'b010);
    acc("lw40", 1'b1, 1'b0, 32'h40, 32'd0, 3'b010);
    bus3.req_store_i = 1'b1; bus3.addr_i = 32'h40;
    bus3.wdata_i = 32'hFFFFFFFF; bus3.funct3_i = 3'b010;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(bus3.busywait_o), 32'd0);
    chk("rstmid_rdata", bus3.rdata_o, 32'd0);
    chk("rstmid_err", 32'(bus3.err_o), 32'd0);
    @(posedge clk);
    #1;
    idle3();
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'd0;
    @(posedge clk);
    #1;
    acc("lw40_nowr", 1'b1, 1'b0, 32'h40, 32'd0, 3'b010);

    // Reset mid-load with request held: restarts with full latency
    drive(1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstheld_busy", 32'(bus3.busywait_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done("rst_restart", 3, 1'b0);

    // LATENCY=1 with request held: busy 1, low 1, busy 1, low 1
    bus1.req_load_i = 1'b1; bus1.addr_i = 32'h10; bus1.funct3_i = 3'b010;
    @(negedge clk);
    chk("l1_busy0", 32'(bus1.busywait_o), 32'd1);
    @(negedge clk);
    chk("l1_low0", 32'(bus1.busywait_o), 32'd0);
    @(negedge clk);
    chk("l1_busy1", 32'(bus1.busywait_o), 32'd1);
    @(posedge clk);
    #1;
    bus1.req_load_i = 1'b0;
    @(negedge clk);
    chk("l1_low1", 32'(bus1.busywait_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
